// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: compare/min/max operation encodings
// and the canonical quiet NaN returned when no ordered operand exists.
package fpu_pkg;

    typedef enum logic [2:0] {
        FCMP_FEQ  = 3'd0,
        FCMP_FLT  = 3'd1,
        FCMP_FLE  = 3'd2,
        FCMP_FMIN = 3'd3,
        FCMP_FMAX = 3'd4
    } fcmp_op_e;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] FP_NEG_ZERO  = 32'h80000000;
    localparam logic [31:0] FP_POS_ZERO  = 32'h00000000;

endpackage

// File: rtl/fcmp_core.sv
// Combinational single-precision compare / min / max.
// Operands order by sign-magnitude with +0 == -0. Define FCMP_NAN_EN to
// make NaN operands unordered (predicates false, min/max pick the other
// operand); without it NaN and infinity order by their raw bits.
module fcmp_core
    import fpu_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [2:0]  op,
    output logic [31:0] z
);

    function automatic logic is_zero(input logic [31:0] a);
        return (a[30:0] == 31'd0);
    endfunction

    // Strict sign-magnitude less-than; the two zeros never compare less.
    function automatic logic less_than(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31] & ~(is_zero(a) & is_zero(b));
        else if (a[31])
            return (a[30:0] > b[30:0]);
        else
            return (a[30:0] < b[30:0]);
    endfunction

    function automatic logic equal(input logic [31:0] a, input logic [31:0] b);
        return (a == b) | (is_zero(a) & is_zero(b));
    endfunction

`ifdef FCMP_NAN_EN
    function automatic logic is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction
`endif

    logic lt;
    logic eq;
    logic both_zero;
    logic x_nan;
    logic y_nan;

    // Evaluate the selected operation on the raw operands.
    always_comb begin
        lt        = less_than(x, y);
        eq        = equal(x, y);
        both_zero = is_zero(x) & is_zero(y);
`ifdef FCMP_NAN_EN
        x_nan     = is_nan(x);
        y_nan     = is_nan(y);
`else
        x_nan     = 1'b0;
        y_nan     = 1'b0;
`endif
        z = '0;
        case (op)
            FCMP_FEQ: z = {31'd0, eq & ~x_nan & ~y_nan};
            FCMP_FLT: z = {31'd0, lt & ~x_nan & ~y_nan};
            FCMP_FLE: z = {31'd0, (lt | eq) & ~x_nan & ~y_nan};
            FCMP_FMIN: begin
                if (x_nan & y_nan)
                    z = FP_CANON_NAN;
                else if (x_nan)
                    z = y;
                else if (y_nan)
                    z = x;
                else if (both_zero)
                    z = (x[31] | y[31]) ? FP_NEG_ZERO : FP_POS_ZERO;
                else
                    z = lt ? x : y;
            end
            FCMP_FMAX: begin
                if (x_nan & y_nan)
                    z = FP_CANON_NAN;
                else if (x_nan)
                    z = y;
                else if (y_nan)
                    z = x;
                else if (both_zero)
                    z = (x[31] & y[31]) ? FP_NEG_ZERO : FP_POS_ZERO;
                else
                    z = lt ? y : x;
            end
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/fcmp_pipe.sv
// Elastic pipelined float compare / min / max with valid-ready handshake.
// The result is computed by fcmp_core ahead of the first register; the
// STAGES registers then carry only result and tag. NaN handling is selected
// by the FCMP_NAN_EN macro inside fcmp_core.
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [31:0]      y,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      z,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [31:0]      res_c;
    logic [STAGES-1:0] vld_p;
    logic [31:0]      res_p [STAGES];
    logic [TAG_W-1:0] tag_p [STAGES];
    logic [STAGES-1:0] load;
    logic             rst_done;

    fcmp_core u_core (
        .x  (x),
        .y  (y),
        .op (op),
        .z  (res_c)
    );

    // A stage may load unless it and every stage after it are full while
    // the consumer stalls; this is the ready chain written without feedback.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            logic full_run;
            full_run = 1'b1;
            for (int j = k; j < STAGES; j++)
                full_run = full_run & vld_p[j];
            load[k] = ~full_run | out_ready;
        end
    end

    // Holds off acceptance until one clock edge has seen reset released.
    always_ff @(posedge clk) begin
        if (!rstn)
            rst_done <= 1'b0;
        else
            rst_done <= 1'b1;
    end

    // Stage registers: stage 0 captures the core result, later stages shift.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_p[k] <= '0;
                tag_p[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_p[0] <= in_valid & in_ready;
                res_p[0] <= res_c;
                tag_p[0] <= tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    res_p[k] <= res_p[k-1];
                    tag_p[k] <= tag_p[k-1];
                end
            end
        end
    end

    assign in_ready  = rstn & rst_done & load[0];
    assign out_valid = vld_p[STAGES-1];
    assign z         = res_p[STAGES-1];
    assign out_tag   = tag_p[STAGES-1];
    assign busy      = |vld_p;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: the driver pushes reference results on
// accept, a monitor pops and compares on every output transfer.
module tb_fcmp_pipe;

    localparam int STAGES = 2;
    localparam int TAG_W  = 6;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      x = '0;
    logic [31:0]      y = '0;
    logic [2:0]       op = '0;
    logic [TAG_W-1:0] tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      z;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    always #5 clk = ~clk;

    fcmp_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    typedef struct { logic [31:0] z; logic [TAG_W-1:0] tag; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] o; logic [TAG_W-1:0] t; } req_t;

    exp_t exp_q[$];
    req_t pend_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    logic [TAG_W-1:0] tag_ctr = '0;
    bit   stall_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: a float maps to a signed integer key (sign applied to the
    // magnitude), so ordering is plain integer comparison and -0 == +0.
    function automatic longint key(input logic [31:0] a);
        longint m;
        m = longint'({33'd0, a[30:0]});
        return a[31] ? -m : m;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        longint ka;
        longint kb;
        bit     bz;
        ka = key(a);
        kb = key(b);
        bz = (ka == 0) && (kb == 0);
`ifdef FCMP_NAN_EN
        begin
            bit na;
            bit nb;
            na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
            nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
            if (o <= 3'd2 && (na || nb)) return 32'd0;
            if ((o == 3'd3 || o == 3'd4) && (na || nb))
                return (na && nb) ? 32'h7FC00000 : (na ? b : a);
        end
`endif
        case (o)
            3'd0: return (ka == kb) ? 32'd1 : 32'd0;
            3'd1: return (ka <  kb) ? 32'd1 : 32'd0;
            3'd2: return (ka <= kb) ? 32'd1 : 32'd0;
            3'd3: begin
                if (bz) return (a[31] || b[31]) ? 32'h80000000 : 32'h00000000;
                return (kb < ka) ? b : a;
            end
            3'd4: begin
                if (bz) return (!a[31] || !b[31]) ? 32'h00000000 : 32'h80000000;
                return (ka < kb) ? b : a;
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        req_t r;
        r.a = a; r.b = b; r.o = o; r.t = tag_ctr;
        tag_ctr++;
        pend_q.push_back(r);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(2))
            0: return $urandom();
            1: case ($urandom_range(9))
                   0: return 32'h00000000;
                   1: return 32'h80000000;
                   2: return 32'h3F800000;
                   3: return 32'hBF800000;
                   4: return 32'h40000000;
                   5: return 32'hC0000000;
                   6: return 32'h7F800000;
                   7: return 32'hFF800000;
                   8: return 32'h00000001;
                   default: return 32'h80000001;
               endcase
            default: return {1'($urandom_range(1)), 8'($urandom_range(120, 134)), 3'($urandom_range(7)), 20'd0};
        endcase
    endfunction

    // Drive pending requests; mode 0 ready high, 1 random ready, 2 stall cycles 3..6.
    task automatic run(input int mode, input int limit);
        int cyc;
        cyc = 0;
        stall_seen = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < limit) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(3) != 0);
                default: out_ready = !(cyc >= 3 && cyc <= 6);
            endcase
            if (pend_q.size() > 0) begin
                in_valid = 1'b1;
                x = pend_q[0].a; y = pend_q[0].b; op = pend_q[0].o; tag = pend_q[0].t;
            end else begin
                in_valid = 1'b0;
            end
            #4;
            if (in_valid && !in_ready) stall_seen = 1;
            if (in_valid && in_ready) begin
                exp_t e;
                e.z = model(x, y, op);
                e.tag = tag;
                exp_q.push_back(e);
                void'(pend_q.pop_front());
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("drain_outstanding", 32'(pend_q.size() + exp_q.size()), 32'd0);
    endtask

    // Single op into an empty pipe with out_ready high; checks exact latency.
    task automatic lat_test(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                            input logic [31:0] zexp);
        logic [TAG_W-1:0] t;
        exp_t e;
        t = tag_ctr;
        tag_ctr++;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; x = a; y = b; op = o; tag = t;
        #4;
        check("lat_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            e.z = zexp; e.tag = t;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        check("lat_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #4;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_z", z, zexp);
        check("lat_tag", 32'(out_tag), 32'(t));
        @(negedge clk);
    endtask

    // Monitor: compare on each output transfer, and check stability under stall.
    initial begin : monitor
        exp_t e;
        bit hold_pend;
        logic [31:0] hold_z;
        logic [TAG_W-1:0] hold_tag;
        hold_pend = 0;
        hold_z = '0;
        hold_tag = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rstn) begin
                hold_pend = 0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_z", z, hold_z);
                    check("hold_tag", 32'(out_tag), 32'(hold_tag));
                end
                hold_pend = 0;
                if (out_valid && !out_ready) begin
                    hold_pend = 1; hold_z = z; hold_tag = out_tag;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL spurious_output: got z=%h tag=%h, required no output", z, out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_z", z, e.z);
                        check("sb_tag", 32'(out_tag), 32'(e.tag));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [31:0] b;
        repeat (3) @(negedge clk);
        #4;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_z", z, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        #4;
        check("in_ready_release_cycle", 32'(in_ready), 32'd0);
        @(negedge clk);
        #4;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        lat_test(32'hBF800000, 32'h3F800000, 3'd1, 32'd1);

        add_op(32'h80000000, 32'h00000000, 3'd0);
        add_op(32'h80000000, 32'h00000000, 3'd3);
        add_op(32'h80000000, 32'h00000000, 3'd4);
        add_op(32'hC0000000, 32'hBF800000, 3'd1);
        add_op(32'hBF800000, 32'hC0000000, 3'd1);
        add_op(32'h3F800000, 32'h40000000, 3'd6);
        run(0, 100);

        for (int i = 0; i < 8; i++)
            add_op(rnd_val(), rnd_val(), 3'd4);
        run(2, 200);
        check("stall_in_ready_dropped", 32'(stall_seen), 32'd1);
        check("busy_after_drain", 32'(busy), 32'd0);

`ifdef FCMP_NAN_EN
        add_op(32'h7FC00001, 32'h3F800000, 3'd2);
        add_op(32'h7FC00001, 32'h3F800000, 3'd3);
        add_op(32'h7FC00001, 32'hFFC00000, 3'd4);
        run(0, 100);
`endif

        // Two ops in flight, then one reset cycle discards them.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        x = 32'h3F800000; y = 32'h40000000; op = 3'd4; tag = 6'h2A;
        #4;
        check("flight_accept0", 32'(in_ready), 32'd1);
        @(negedge clk);
        x = 32'hC0000000; tag = 6'h15;
        #4;
        check("flight_accept1", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; rstn = 1'b0;
        #4;
        check("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #4;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_z", z, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        lat_test(32'hC0000000, 32'hBF800000, 3'd2, 32'd1);

        for (int i = 0; i < 300; i++) begin
            a = rnd_val();
            case ($urandom_range(3))
                0: b = a;
                1: b = a ^ 32'h80000000;
                default: b = rnd_val();
            endcase
            add_op(a, b, 3'($urandom_range(7)));
        end
        run(1, 3000);

        for (int i = 0; i < 100; i++)
            add_op(rnd_val(), rnd_val(), 3'($urandom_range(4)));
        run(0, 1000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
